// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
//
// Turns raw player inputs into one-cycle move/rotate strobes for tetris_grid.
//   - Joystick X (12-bit ADC result) is decoded into LEFT/RIGHT with
//     hysteresis. A held direction auto-repeats: the first strobe is followed
//     by a DAS delay, then by ARR-period repeats.
//   - Pushbuttons s1 (rotate) and s2 (soft drop) are synchronised (2 FF),
//     debounced and edge-detected. Pressing both together raises reset_req
//     and produces no rotate/move_down pulse.
//   - freeze forces the joystick FSM to IDLE and suppresses every strobe.
//     Debouncing and reset_req keep running while frozen.
//
// Optional feature (compile-time macro TETRIS_INPUT_DOWN_REPEAT_EN):
//   defined   - holding s2 alone auto-repeats move_down with the same
//               DAS/ARR timing as the joystick, using its own counter.
//               The repeat stops on s2 release, s1 press or freeze.
//   undefined - one move_down strobe per press; no repeat logic is built.
//
// Ports
//   clk         in   system clock (50 MHz)
//   reset       in   asynchronous, active-high reset
//   adc_value   in   [11:0] joystick X ADC result, synchronous to clk
//   s1          in   raw rotate button, pressed = 1, asynchronous
//   s2          in   raw soft-drop button, pressed = 1, asynchronous
//   freeze      in   forces FSM to IDLE and suppresses all strobes
//   move_left   out  one-cycle strobe
//   move_right  out  one-cycle strobe
//   move_down   out  one-cycle strobe
//   rotate      out  one-cycle strobe
//   reset_req   out  level, high while both debounced buttons are high
// -----------------------------------------------------------------------------
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DAS_CYCLES      = 8_000_000,
  parameter int ARR_CYCLES      = 2_500_000,
  parameter int THRESH_HI       = 1750,
  parameter int THRESH_LO       = 1550,
  parameter int HYST            = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] adc_value,
  input  logic        s1,
  input  logic        s2,
  input  logic        freeze,
  output logic        move_left,
  output logic        move_right,
  output logic        move_down,
  output logic        rotate,
  output logic        reset_req
);

  // One counter width covers every timer; the largest terminal value is
  // MAX-1, so $clog2(MAX) bits can never wrap.
  localparam int MAX_RPT = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int MAX_CYC = (MAX_RPT > DEBOUNCE_CYCLES) ? MAX_RPT : DEBOUNCE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DAS_LAST = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);

  localparam logic [11:0] TH_HI  = 12'(THRESH_HI);
  localparam logic [11:0] TH_LO  = 12'(THRESH_LO);
  localparam logic [11:0] R_EXIT = 12'(THRESH_HI - HYST);
  localparam logic [11:0] L_EXIT = 12'(THRESH_LO + HYST);

  // Joystick FSM encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] L_DAS = 3'd1;
  localparam logic [2:0] L_ARR = 3'd2;
  localparam logic [2:0] R_DAS = 3'd3;
  localparam logic [2:0] R_ARR = 3'd4;

  // ---------------------------------------------------------------------------
  // Buttons: bit 0 = s1 (rotate), bit 1 = s2 (soft drop)
  // ---------------------------------------------------------------------------
  logic [1:0]    sync_m;
  logic [1:0]    sync_s;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [CW-1:0] db_cnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_m <= '0;
      sync_s <= '0;
      deb    <= '0;
      deb_d  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_m <= {s2, s1};
      sync_s <= sync_m;
      deb_d  <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_s[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // A rise only counts while the other button is released, so a
  // simultaneous press of both yields neither strobe.
  logic rot_rise;
  logic dn_rise;

  assign rot_rise = deb[0] & ~deb_d[0] & ~deb[1];
  assign dn_rise  = deb[1] & ~deb_d[1] & ~deb[0];

  // ---------------------------------------------------------------------------
  // Joystick FSM
  // ---------------------------------------------------------------------------
  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          left_nx;
  logic          right_nx;
  logic          go_right;
  logic          go_left;
  logic          r_exit;
  logic          l_exit;

  assign go_right = adc_value > TH_HI;
  assign go_left  = adc_value < TH_LO;
  assign r_exit   = adc_value <= R_EXIT;
  assign l_exit   = adc_value >= L_EXIT;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    left_nx  = 1'b0;
    right_nx = 1'b0;
    if (freeze) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (go_right) begin
            state_nx = R_DAS;
            right_nx = 1'b1;
          end else if (go_left) begin
            state_nx = L_DAS;
            left_nx  = 1'b1;
          end
        end
        R_DAS, R_ARR: begin
          // A hard swing to the left wins over the plain right exit.
          if (go_left) begin
            state_nx = L_DAS;
            cnt_nx   = '0;
            left_nx  = 1'b1;
          end else if (r_exit) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == ((state == R_DAS) ? DAS_LAST : ARR_LAST)) begin
            state_nx = R_ARR;
            cnt_nx   = '0;
            right_nx = 1'b1;
          end
        end
        L_DAS, L_ARR: begin
          if (go_right) begin
            state_nx = R_DAS;
            cnt_nx   = '0;
            right_nx = 1'b1;
          end else if (l_exit) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == ((state == L_DAS) ? DAS_LAST : ARR_LAST)) begin
            state_nx = L_ARR;
            cnt_nx   = '0;
            left_nx  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Soft drop
  // ---------------------------------------------------------------------------
  logic down_nx;

`ifdef TETRIS_INPUT_DOWN_REPEAT_EN
  localparam logic [1:0] D_OFF = 2'd0;
  localparam logic [1:0] D_DAS = 2'd1;
  localparam logic [1:0] D_ARR = 2'd2;

  logic [1:0]    dstate;
  logic [1:0]    dstate_nx;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] dcnt_nx;

  always_comb begin
    dstate_nx = dstate;
    dcnt_nx   = dcnt + CW'(1);
    down_nx   = 1'b0;
    if (freeze || !deb[1] || deb[0]) begin
      dstate_nx = D_OFF;
      dcnt_nx   = '0;
    end else if (dn_rise) begin
      dstate_nx = D_DAS;
      dcnt_nx   = '0;
      down_nx   = 1'b1;
    end else begin
      case (dstate)
        D_DAS: begin
          if (dcnt == DAS_LAST) begin
            dstate_nx = D_ARR;
            dcnt_nx   = '0;
            down_nx   = 1'b1;
          end
        end
        D_ARR: begin
          if (dcnt == ARR_LAST) begin
            dcnt_nx = '0;
            down_nx = 1'b1;
          end
        end
        default: begin
          // Held without a fresh press (e.g. after a cancel): stay idle.
          dstate_nx = D_OFF;
          dcnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate <= D_OFF;
      dcnt   <= '0;
    end else begin
      dstate <= dstate_nx;
      dcnt   <= dcnt_nx;
    end
  end
`else
  assign down_nx = dn_rise & ~freeze;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_down  <= 1'b0;
      rotate     <= 1'b0;
      reset_req  <= 1'b0;
    end else begin
      move_left  <= left_nx;
      move_right <= right_nx;
      move_down  <= down_nx;
      rotate     <= rot_rise & ~freeze;
      reset_req  <= deb[0] & deb[1];
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
module tb_tetris_input_ctrl;

  localparam int DB  = 4;
  localparam int DAS = 10;
  localparam int ARR = 3;
  localparam int HI  = 1750;
  localparam int LO  = 1550;
  localparam int HY  = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_value;
  logic        s1;
  logic        s2;
  logic        freeze;
  logic        move_left;
  logic        move_right;
  logic        move_down;
  logic        rotate;
  logic        reset_req;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR),
    .THRESH_HI      (HI),
    .THRESH_LO      (LO),
    .HYST           (HY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adc_value (adc_value),
    .s1        (s1),
    .s2        (s2),
    .freeze    (freeze),
    .move_left (move_left),
    .move_right(move_right),
    .move_down (move_down),
    .rotate    (rotate),
    .reset_req (reset_req)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model. Time is an absolute edge number n; repeat strobes are
  // "due" at fixed offsets from the edge the hold started.
  // ---------------------------------------------------------------------------
  int         n = 0;
  logic [1:0] pipe1, pipe2;       // button samples delayed by two edges
  logic [1:0] lvl, lvl_prev;      // accepted button levels (after n, after n-1)
  int         streak [2];         // consecutive edges synced level disagreed
  int         jdir, jt0;          // stick direction -1/0/+1 and hold start
  bit         dact;
  int         dt0;
  logic       e_left, e_right, e_down, e_rot, e_rr;

  function automatic bit due(int k);
    return (k == DAS) || (k > DAS && ((k - DAS) % ARR) == 0);
  endfunction

  task automatic model_reset();
    pipe1 = '0; pipe2 = '0; lvl = '0; lvl_prev = '0;
    streak[0] = 0; streak[1] = 0;
    jdir = 0; jt0 = 0; dact = 0; dt0 = 0;
    e_left = 0; e_right = 0; e_down = 0; e_rot = 0; e_rr = 0;
  endtask

  task automatic model_step();
    logic [1:0] old, older, synced;
    int a;
    n++;
    if (reset) begin
      model_reset();
      return;
    end
    old   = lvl;
    older = lvl_prev;
    a     = int'(adc_value);
    e_left = 0; e_right = 0; e_down = 0;
    e_rr  = old[0] & old[1];
    e_rot = old[0] & ~older[0] & ~old[1] & ~freeze;
`ifdef TETRIS_INPUT_DOWN_REPEAT_EN
    if (freeze || !old[1] || old[0]) dact = 0;
    else if (!older[1]) begin dact = 1; dt0 = n; e_down = 1; end
    else if (dact && due(n - dt0)) e_down = 1;
`else
    e_down = old[1] & ~older[1] & ~old[0] & ~freeze;
`endif
    if (freeze) jdir = 0;
    else if (jdir == 0) begin
      if (a > HI) begin jdir = 1; jt0 = n; e_right = 1; end
      else if (a < LO) begin jdir = -1; jt0 = n; e_left = 1; end
    end else if (jdir > 0) begin
      if (a < LO) begin jdir = -1; jt0 = n; e_left = 1; end
      else if (a <= HI - HY) jdir = 0;
      else if (due(n - jt0)) e_right = 1;
    end else begin
      if (a > HI) begin jdir = 1; jt0 = n; e_right = 1; end
      else if (a >= LO + HY) jdir = 0;
      else if (due(n - jt0)) e_left = 1;
    end
    synced = pipe2; pipe2 = pipe1; pipe1 = {s2, s1};
    lvl_prev = old;
    for (int i = 0; i < 2; i++) begin
      if (synced[i] != lvl[i]) begin
        streak[i]++;
        if (streak[i] == DB) begin lvl[i] = synced[i]; streak[i] = 0; end
      end else streak[i] = 0;
    end
  endtask

  task automatic chk(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0b exp=%0b", name, n, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", name, n, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("move_left",  move_left,  e_left);
    chk("move_right", move_right, e_right);
    chk("move_down",  move_down,  e_down);
    chk("rotate",     rotate,     e_rot);
    chk("reset_req",  reset_req,  e_rr);
    chk("lr_exclusive", move_left & move_right, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic int pos_at(int q[$], int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  int adc_set [18] = '{1000, 1540, 1549, 1550, 1551, 1599, 1600, 1601, 1650,
                       1699, 1700, 1701, 1749, 1750, 1751, 1760, 2000, 3000};

  initial begin
    int rpos[$];
    int lpos[$];
    int opos[$];
    int cnt_a, cnt_b, adc_hold, frz_hold;

    reset = 1'b1; adc_value = 12'd1650; s1 = 0; s2 = 0; freeze = 0;
    model_reset();
    repeat (3) cyc();
    chk("reset_outputs", |{move_left, move_right, move_down, rotate, reset_req}, 1'b0);
    reset = 1'b0;
    repeat (3) cyc();

    // Hold right: strobes at 1, 11, 14, 17, ... 29
    adc_value = 12'd2000; rpos.delete(); cnt_a = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (move_right) rpos.push_back(i);
      if (move_left) cnt_a++;
    end
    chk_int("hold_r_first", pos_at(rpos, 0), 1);
    chk_int("hold_r_das",   pos_at(rpos, 1), 11);
    chk_int("hold_r_arr",   pos_at(rpos, 2), 14);
    chk_int("hold_r_count", rpos.size(), 8);
    chk_int("hold_r_noleft", cnt_a, 0);

    // Inside the hysteresis band the stick stays right (repeats at 32, 35)
    adc_value = 12'd1720; cnt_a = 0;
    for (int i = 1; i <= 5; i++) begin cyc(); if (move_right) cnt_a++; end
    chk_int("hyst_stays_right", cnt_a, 2);
    adc_value = 12'd1700; cnt_a = 0;
    for (int i = 1; i <= 3; i++) begin cyc(); cnt_a += int'(move_right) + int'(move_left); end
    chk_int("release_no_pulse", cnt_a, 0);
    adc_value = 12'd1000; lpos.delete();
    for (int i = 1; i <= 5; i++) begin cyc(); if (move_left) lpos.push_back(i); end
    chk_int("left_first", pos_at(lpos, 0), 1);
    chk_int("left_count", lpos.size(), 1);
    adc_value = 12'd1650;
    repeat (5) cyc();

    // Bouncing s1 then steady: one rotate 7 cycles after steady
    cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      s1 = ((i / 2) % 2) == 0;
      cyc();
      if (rotate) cnt_a++;
    end
    s1 = 1; opos.delete();
    for (int i = 1; i <= 20; i++) begin cyc(); if (rotate) opos.push_back(i); end
    chk_int("bounce_no_rotate", cnt_a, 0);
    chk_int("rotate_pos", pos_at(opos, 0), 7);
    chk_int("rotate_count", opos.size(), 1);
    s1 = 0;
    repeat (12) cyc();

    // Both buttons together: reset_req only
    s1 = 1; s2 = 1; cnt_a = 0; opos.delete();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      cnt_a += int'(rotate) + int'(move_down);
      if (reset_req) opos.push_back(i);
    end
    chk_int("both_no_strobe", cnt_a, 0);
    chk_int("reset_req_rise", pos_at(opos, 0), 7);
    chk("reset_req_held", reset_req, 1'b1);
    s1 = 0; s2 = 0;
    repeat (12) cyc();
    chk("reset_req_drop", reset_req, 1'b0);

    // Soft drop held
    s2 = 1; opos.delete();
    for (int i = 1; i <= 30; i++) begin cyc(); if (move_down) opos.push_back(i); end
    chk_int("down_first", pos_at(opos, 0), 7);
`ifdef TETRIS_INPUT_DOWN_REPEAT_EN
    chk_int("down_das", pos_at(opos, 1), 17);
    chk_int("down_arr", pos_at(opos, 2), 20);
    chk_int("down_count", opos.size(), 6);
`else
    chk_int("down_count", opos.size(), 1);
`endif
    s2 = 0;
    repeat (12) cyc();

    // Freeze with stick held
    adc_value = 12'd2000;
    repeat (4) cyc();
    freeze = 1; cnt_a = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      cnt_a += int'(move_left) + int'(move_right) + int'(move_down) + int'(rotate);
    end
    chk_int("freeze_silent", cnt_a, 0);
    freeze = 0;
    cyc();
    chk("unfreeze_strobe", move_right, 1'b1);

    // Reset in R_ARR while a strobe is on the outputs
    repeat (13) cyc();
    chk("pre_reset_strobe", move_right, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1 chk("async_reset_right", move_right, 1'b0);
    compare_all();
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("post_reset_strobe", move_right, 1'b1);

    // Randomised run
    adc_hold = 0; frz_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (adc_hold == 0) begin
        adc_value = 12'(adc_set[$urandom_range(0, 17)]);
        adc_hold  = $urandom_range(1, 30);
      end else adc_hold--;
      if ($urandom_range(0, 9) == 0) s1 = ~s1;
      if ($urandom_range(0, 9) == 0) s2 = ~s2;
      if (frz_hold > 0) frz_hold--;
      else if ($urandom_range(0, 99) < 3) frz_hold = $urandom_range(1, 6);
      freeze = (frz_hold > 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
